// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared sizes and types for the 1RW SRAM FIFO controller.
// Holds default geometry, pointer/data types and the port-op encoding.
package sram_fifo_pkg;

   localparam int FIFO_DEPTH = 32;
   localparam int FIFO_WIDTH = 36;
   localparam int FIFO_AW    = 5;

   typedef logic [FIFO_AW:0]      ptr_t;
   typedef logic [FIFO_WIDTH-1:0] data_t;

   typedef enum logic {
      OP_WRITE = 1'b0,
      OP_READ  = 1'b1
   } op_e;

endpackage

// File: rtl/sram_fifo_obuf.sv
// sram_fifo_obuf: 2-entry output buffer with push/pop/cnt.
// Ports: clock, reset_n, push/push_data in, pop in, valid/data/cnt out.
module sram_fifo_obuf #(
   parameter int WIDTH = 36
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [1:0]       cnt
);

   logic [WIDTH-1:0] e0;
   logic [WIDTH-1:0] e1;
   logic             pop_ok;

   assign pop_ok = pop && (cnt != 2'd0);
   assign valid  = (cnt != 2'd0);
   assign data   = e0;

   // e0 is always the head; e1 only holds data when cnt == 2.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= 2'd0;
         e0  <= '0;
         e1  <= '0;
      end else begin
         unique case ({push, pop_ok})
            2'b10: begin
               if (cnt == 2'd0) e0 <= push_data;
               else             e1 <= push_data;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               e0  <= e1;
               cnt <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd2) begin
                  e0 <= e1;
                  e1 <= push_data;
               end else begin
                  e0 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/sram_1rw_fifo_ctrl.sv
// sram_1rw_fifo_ctrl: ready/valid FIFO on one 1RW SRAM macro.
// Ports: enq_*, deq_* handshakes; sram_* macro pins; count = SRAM occupancy.
module sram_1rw_fifo_ctrl
   import sram_fifo_pkg::*;
#(
   parameter int DEPTH  = FIFO_DEPTH,
   parameter int WIDTH  = FIFO_WIDTH,
   parameter int ADDR_W = FIFO_AW
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enq_valid,
   output logic              enq_ready,
   input  logic [WIDTH-1:0]  enq_bits,
   output logic              deq_valid,
   input  logic              deq_ready,
   output logic [WIDTH-1:0]  deq_bits,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_en,
   output logic              sram_wmode,
   output logic [WIDTH-1:0]  sram_wdata,
   input  logic [WIDTH-1:0]  sram_rdata,
   output logic [ADDR_W:0]   count
);

   logic [ADDR_W:0]   wptr;
   logic [ADDR_W:0]   rptr;
   logic              inflight;
   op_e               last_op;
   logic              run;
   logic [ADDR_W-1:0] addr_q;
   logic [WIDTH-1:0]  wdata_q;
   logic [1:0]        buf_cnt;

   logic              mem_empty;
   logic              mem_full;
   logic [2:0]        occ;
   logic              rd_want;
   logic              bypass;
   logic              wr_cand;
   logic              rd_issue;
   logic              enq_fire;
   logic              wr_issue;
   logic              byp_push;
   logic              ob_push;
   logic [WIDTH-1:0]  ob_data;

   assign mem_empty = (wptr == rptr);
   assign mem_full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                      (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

   // Buffer slots already promised: held entries plus a read in flight.
   assign occ     = {1'b0, buf_cnt} + {2'b0, inflight};
   assign rd_want = run && !mem_empty && (occ < 3'd2);
   assign bypass  = run && mem_empty && !inflight && (buf_cnt < 2'd2);

   // A write only contends when it could actually go to the SRAM.
   assign wr_cand  = run && enq_valid && !mem_full && !bypass;
   assign rd_issue = rd_want && !(wr_cand && last_op == OP_READ);

   assign enq_ready = run && (bypass || (!mem_full && !rd_issue));
   assign enq_fire  = enq_valid && enq_ready;
   assign wr_issue  = enq_fire && !bypass;
   assign byp_push  = enq_fire && bypass;

   // Bypass never coincides with a capture: it needs !inflight.
   assign ob_push = byp_push || inflight;
   assign ob_data = inflight ? sram_rdata : enq_bits;

   assign count = wptr - rptr;

   always_comb begin
      sram_en    = 1'b0;
      sram_wmode = 1'b0;
      sram_addr  = addr_q;
      sram_wdata = wdata_q;
      unique case (1'b1)
         rd_issue: begin
            sram_en   = 1'b1;
            sram_addr = rptr[ADDR_W-1:0];
         end
         wr_issue: begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = wptr[ADDR_W-1:0];
            sram_wdata = enq_bits;
         end
         default: ;
      endcase
   end

   // run holds everything off for the first cycle after reset release.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr     <= '0;
         rptr     <= '0;
         inflight <= 1'b0;
         last_op  <= OP_WRITE;
         run      <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         run      <= 1'b1;
         inflight <= rd_issue;
         addr_q   <= sram_addr;
         wdata_q  <= sram_wdata;
         if (wr_issue) begin
            wptr    <= wptr + 1'b1;
            last_op <= OP_WRITE;
         end
         if (rd_issue) begin
            rptr    <= rptr + 1'b1;
            last_op <= OP_READ;
         end
      end
   end

   sram_fifo_obuf #(
      .WIDTH(WIDTH)
   ) u_obuf (
      .clock    (clock),
      .reset_n  (reset_n),
      .push     (ob_push),
      .push_data(ob_data),
      .pop      (deq_ready),
      .valid    (deq_valid),
      .data     (deq_bits),
      .cnt      (buf_cnt)
   );

endmodule
